psram_arbiter: RTL and testbench

PSRAM_ARBITER -- requirements
Module: psram_arbiter

---
 rtl/psram_arbiter_if.sv | 52 +++++
 rtl/psram_arbiter.sv | 151 +++++++++++++++
 tb/tb_psram_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_arbiter_if.sv
// -----------------------------------------------------------------------------
// psram_arbiter_if
// Bundles the two client ports and the PSRAM controller command port of the
// PSRAM arbiter.
//   c0_*  : client 0 (PPU pattern fetch, high priority)
//   c1_*  : client 1 (CPU / SD loader)
//   mem_* : command/data port towards the PSRAM controller
// Modports:
//   slave  : arbiter side (serves the clients, drives the controller)
//   master : client/controller side (testbench or surrounding fabric)
// -----------------------------------------------------------------------------
interface psram_arbiter_if;
  // client 0
  logic        c0_req;
  logic        c0_we;
  logic [19:0] c0_adrs;
  logic [15:0] c0_wdata;
  logic        c0_ack;
  logic [15:0] c0_rdata;
  // client 1
  logic        c1_req;
  logic        c1_we;
  logic [19:0] c1_adrs;
  logic [15:0] c1_wdata;
  logic        c1_ack;
  logic [15:0] c1_rdata;
  // controller
  logic        mem_read;
  logic        mem_write;
  logic [19:0] mem_adrs;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        mem_busy;

  modport slave (
    input  c0_req, c0_we, c0_adrs, c0_wdata,
    output c0_ack, c0_rdata,
    input  c1_req, c1_we, c1_adrs, c1_wdata,
    output c1_ack, c1_rdata,
    output mem_read, mem_write, mem_adrs, mem_din,
    input  mem_dout, mem_busy
  );

  modport master (
    output c0_req, c0_we, c0_adrs, c0_wdata,
    input  c0_ack, c0_rdata,
    output c1_req, c1_we, c1_adrs, c1_wdata,
    input  c1_ack, c1_rdata,
    input  mem_read, mem_write, mem_adrs, mem_din,
    output mem_dout, mem_busy
  );
endinterface

// File: rtl/psram_arbiter.sv
// -----------------------------------------------------------------------------
// psram_arbiter
// Two-client arbiter in front of a single-port PSRAM controller. One
// transaction is outstanding at a time. Client 0 has fixed priority, but a
// starvation counter hands the memory to client 1 after STARVE_LIMIT
// consecutive client-0 grants while client 1 is waiting.
//
// Ports:
//   clk    : single clock shared with the PSRAM controller (rising edge)
//   resetn : asynchronous active-low reset
//   bus    : psram_arbiter_if.slave -- client req/ack/data and controller port
//
// Transaction flow: IDLE -> CMD (one-cycle mem_read/mem_write) -> WAIT_HI
// (controller picks the command up, or 3-cycle timeout) -> WAIT_LO
// (controller finishes, read data captured) -> DONE (one-cycle ack) -> IDLE.
// -----------------------------------------------------------------------------
module psram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4  // 1..15
) (
  input  logic           clk,
  input  logic           resetn,
  psram_arbiter_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_WAIT_HI = 3'd2;
  localparam logic [2:0] S_WAIT_LO = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [3:0] LP_LIMIT  = 4'(STARVE_LIMIT);
  localparam logic [1:0] LP_HI_TMO = 2'd2;  // last r_wait value of 3 WAIT_HI cycles

  logic [2:0]  r_state;
  logic        r_armed;     // set one edge after reset release
  logic        r_sel;       // granted client: 0 = c0, 1 = c1
  logic        r_we;
  logic [3:0]  r_starve;
  logic [1:0]  r_wait;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [19:0] r_mem_adrs;
  logic [15:0] r_mem_din;
  logic        r_c0_ack;
  logic        r_c1_ack;
  logic [15:0] r_c0_rdata;
  logic [15:0] r_c1_rdata;

  logic        w_any_req;
  logic        w_pick_c1;
  logic        w_grant;
  logic        w_grant_we;
  logic [3:0]  w_starve_inc;

  assign w_any_req  = bus.c0_req | bus.c1_req;
  // c1 wins when c0 is silent, or when c0 has been favoured long enough.
  assign w_pick_c1  = bus.c1_req & (~bus.c0_req | (r_starve >= LP_LIMIT));
  // r_armed delays the first arbitration so no command leaves on the first
  // edge after reset release.
  assign w_grant    = (r_state == S_IDLE) & r_armed & ~bus.mem_busy & w_any_req;
  assign w_grant_we = w_pick_c1 ? bus.c1_we : bus.c0_we;
  assign w_starve_inc = (r_starve == 4'hF) ? r_starve : r_starve + 4'd1;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the read-data holding registers are cleared too, because the
      // clients must observe all-zero outputs while reset is asserted.
      r_state     <= S_IDLE;
      r_armed     <= 1'b0;
      r_sel       <= 1'b0;
      r_we        <= 1'b0;
      r_starve    <= '0;
      r_wait      <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_adrs  <= '0;
      r_mem_din   <= '0;
      r_c0_ack    <= 1'b0;
      r_c1_ack    <= 1'b0;
      r_c0_rdata  <= '0;
      r_c1_rdata  <= '0;
    end else begin
      r_armed     <= 1'b1;
      // command and ack strobes are single-cycle by default
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_c0_ack    <= 1'b0;
      r_c1_ack    <= 1'b0;

      if (!bus.c1_req)
        r_starve <= '0;
      else if (w_grant)
        r_starve <= w_pick_c1 ? 4'd0 : w_starve_inc;

      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_sel       <= w_pick_c1;
            r_we        <= w_grant_we;
            r_mem_adrs  <= w_pick_c1 ? bus.c1_adrs  : bus.c0_adrs;
            r_mem_din   <= w_pick_c1 ? bus.c1_wdata : bus.c0_wdata;
            // strobe is registered so it is high exactly while in CMD
            r_mem_read  <= ~w_grant_we;
            r_mem_write <= w_grant_we;
            r_state     <= S_CMD;
          end
        end
        S_CMD: begin
          r_wait  <= '0;
          r_state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          // a controller that finishes instantly never shows busy; give up
          // after three cycles and treat the access as complete
          if (bus.mem_busy || (r_wait == LP_HI_TMO))
            r_state <= S_WAIT_LO;
          else
            r_wait <= r_wait + 2'd1;
        end
        S_WAIT_LO: begin
          if (!bus.mem_busy) begin
            if (!r_we) begin
              if (r_sel) r_c1_rdata <= bus.mem_dout;
              else       r_c0_rdata <= bus.mem_dout;
            end
            r_c0_ack <= ~r_sel;
            r_c1_ack <= r_sel;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          // requests are re-sampled only after the client has seen ack
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_adrs  = r_mem_adrs;
  assign bus.mem_din   = r_mem_din;
  assign bus.c0_ack    = r_c0_ack;
  assign bus.c1_ack    = r_c1_ack;
  assign bus.c0_rdata  = r_c0_rdata;
  assign bus.c1_rdata  = r_c1_rdata;

endmodule

// File: tb/tb_psram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_psram_arbiter
// Directed bench for psram_arbiter (STARVE_LIMIT = 4). A small controller
// model raises mem_busy for busy_len cycles after each command (never, when
// busy_len is 0) and returns model_dout as read data. Inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_psram_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  psram_arbiter_if bus ();

  psram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- controller model ----------------
  int          busy_len   = 0;
  logic        model_busy = 1'b0;
  logic [15:0] model_dout = 16'h0000;
  int          rem        = 0;
  int          n_reads    = 0;
  int          n_writes   = 0;
  int          n_both     = 0;
  int          n_long     = 0;
  logic        prev_cmd   = 1'b0;

  assign bus.mem_busy = model_busy;
  assign bus.mem_dout = model_dout;

  always @(posedge clk) begin
    if (bus.mem_read)  n_reads  <= n_reads + 1;
    if (bus.mem_write) n_writes <= n_writes + 1;
    if (bus.mem_read && bus.mem_write) n_both <= n_both + 1;
    if ((bus.mem_read || bus.mem_write) && prev_cmd) n_long <= n_long + 1;
    prev_cmd <= bus.mem_read || bus.mem_write;
    if ((bus.mem_read || bus.mem_write) && busy_len > 0) begin
      model_busy <= 1'b1;
      rem        <= busy_len;
    end else if (rem > 1) begin
      rem <= rem - 1;
    end else begin
      rem        <= 0;
      model_busy <= 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_ack(input int budget, output int cyc,
                          output logic a0, output logic a1);
    a0 = 1'b0; a1 = 1'b0; cyc = 0;
    while (!a0 && !a1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      a0 = bus.c0_ack;
      a1 = bus.c1_ack;
    end
    total++;
    if (!a0 && !a1) begin
      bad++;
      $display("FAIL ack_timeout: got no ack, required one within %0d cycles", budget);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    total++;
    if ({bus.c0_ack, bus.c1_ack, bus.mem_read, bus.mem_write} !== 4'b0000) begin
      bad++;
      $display("FAIL %s_strobes: got %b required 0000", tag,
               {bus.c0_ack, bus.c1_ack, bus.mem_read, bus.mem_write});
    end
    total++;
    if (bus.mem_adrs !== 20'h0 || bus.mem_din !== 16'h0) begin
      bad++;
      $display("FAIL %s_mem_bus: got adrs=%h din=%h required 0/0", tag, bus.mem_adrs, bus.mem_din);
    end
    total++;
    if (bus.c0_rdata !== 16'h0 || bus.c1_rdata !== 16'h0) begin
      bad++;
      $display("FAIL %s_rdata: got c0=%h c1=%h required 0/0", tag, bus.c0_rdata, bus.c1_rdata);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int cyc; logic a0, a1;
    resetn = 1'b0;
    bus.c0_req = 0; bus.c0_we = 0; bus.c0_adrs = '0; bus.c0_wdata = '0;
    bus.c1_req = 0; bus.c1_we = 0; bus.c1_adrs = '0; bus.c1_wdata = '0;
    busy_len = 2; model_dout = 16'h7777;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    // request already pending at release: first edge must not issue
    bus.c0_req = 1; bus.c0_we = 0; bus.c0_adrs = 20'h00123;
    resetn = 1'b1;
    @(negedge clk);
    total++;
    if (bus.mem_read !== 1'b0) begin
      bad++; $display("FAIL first_edge_cmd: got mem_read=%b required 0", bus.mem_read);
    end
    @(negedge clk);
    total++;
    if (bus.mem_read !== 1'b1 || bus.mem_adrs !== 20'h00123) begin
      bad++; $display("FAIL second_edge_cmd: got read=%b adrs=%h required 1/00123",
                      bus.mem_read, bus.mem_adrs);
    end
    wait_ack(30, cyc, a0, a1);
    bus.c0_req = 0;
    total++;
    if (!a0 || a1 || bus.c0_rdata !== 16'h7777) begin
      bad++; $display("FAIL post_reset_read: got a0=%b a1=%b rdata=%h required 1/0/7777",
                      a0, a1, bus.c0_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_c0_read;
    int r0, w0, cyc; logic got, saw_c1;
    busy_len = 5; model_dout = 16'hBEEF;
    r0 = n_reads; w0 = n_writes;
    bus.c0_req = 1; bus.c0_we = 0; bus.c0_adrs = 20'h00010;
    got = 0; saw_c1 = 0; cyc = 0;
    while (!got && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_read && bus.mem_adrs !== 20'h00010) begin
        total++; bad++;
        $display("FAIL c0_read_adrs: got %h required 00010", bus.mem_adrs);
      end
      if (bus.c1_ack) saw_c1 = 1;
      if (bus.c0_ack) got = 1;
    end
    bus.c0_req = 0;
    total++;
    if (!got || cyc > 9) begin
      bad++; $display("FAIL c0_read_latency: got ack=%b after %0d cycles required ack within 9", got, cyc);
    end
    @(negedge clk);
    total++;
    if (bus.c0_ack !== 1'b0 || bus.c1_ack !== 1'b0 || saw_c1) begin
      bad++; $display("FAIL c0_read_ack_pulse: got c0_ack=%b c1_ack=%b saw_c1=%b required 0/0/0",
                      bus.c0_ack, bus.c1_ack, saw_c1);
    end
    total++;
    if (bus.c0_rdata !== 16'hBEEF) begin
      bad++; $display("FAIL c0_read_data: got %h required BEEF", bus.c0_rdata);
    end
    total++;
    if (n_reads - r0 != 1 || n_writes - w0 != 0) begin
      bad++; $display("FAIL c0_read_cmds: got reads=%0d writes=%0d required 1/0",
                      n_reads - r0, n_writes - w0);
    end
  endtask

  task automatic test_c1_write;
    int r0, w0, cyc; logic got, saw_c0, started, unstable;
    busy_len = 3; model_dout = 16'hAAAA;
    r0 = n_reads; w0 = n_writes;
    bus.c1_req = 1; bus.c1_we = 1; bus.c1_adrs = 20'hFFFFF; bus.c1_wdata = 16'h1234;
    got = 0; saw_c0 = 0; started = 0; unstable = 0; cyc = 0;
    while (!got && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_write) started = 1;
      if (started && (bus.mem_adrs !== 20'hFFFFF || bus.mem_din !== 16'h1234)) unstable = 1;
      if (bus.c0_ack) saw_c0 = 1;
      if (bus.c1_ack) got = 1;
    end
    bus.c1_req = 0; bus.c1_we = 0;
    total++;
    if (!got || saw_c0) begin
      bad++; $display("FAIL c1_write_ack: got c1_ack=%b saw_c0=%b required 1/0", got, saw_c0);
    end
    total++;
    if (!started || unstable) begin
      bad++; $display("FAIL c1_write_bus: got started=%b unstable=%b required 1/0", started, unstable);
    end
    total++;
    if (n_writes - w0 != 1 || n_reads - r0 != 0) begin
      bad++; $display("FAIL c1_write_cmds: got writes=%0d reads=%0d required 1/0",
                      n_writes - w0, n_reads - r0);
    end
    total++;
    if (bus.c1_rdata !== 16'h0000) begin
      bad++; $display("FAIL c1_write_rdata: got %h required 0000", bus.c1_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_simultaneous;
    int cyc; logic a0, a1;
    busy_len = 2; model_dout = 16'h3C3C;
    bus.c0_req = 1; bus.c0_we = 0; bus.c0_adrs = 20'h00AAA;
    bus.c1_req = 1; bus.c1_we = 0; bus.c1_adrs = 20'h00BBB;
    wait_ack(30, cyc, a0, a1);
    bus.c0_req = 0;
    total++;
    if (!a0 || a1) begin
      bad++; $display("FAIL simul_first: got a0=%b a1=%b required 1/0", a0, a1);
    end
    @(negedge clk);  // DONE -> IDLE
    @(negedge clk);  // IDLE grants c1 on this edge
    total++;
    if (bus.mem_read !== 1'b1 || bus.mem_adrs !== 20'h00BBB) begin
      bad++; $display("FAIL simul_second_cmd: got read=%b adrs=%h required 1/00BBB",
                      bus.mem_read, bus.mem_adrs);
    end
    wait_ack(30, cyc, a0, a1);
    bus.c1_req = 0;
    total++;
    if (a0 || !a1 || bus.c1_rdata !== 16'h3C3C) begin
      bad++; $display("FAIL simul_second: got a0=%b a1=%b rdata=%h required 0/1/3C3C",
                      a0, a1, bus.c1_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_starve;
    int cyc; logic a0, a1, both;
    logic [9:0] order;
    logic [9:0] exp_order;
    exp_order = 10'b10_0001_0000;  // bit i = 1 when grant i goes to c1
    busy_len = 1; model_dout = 16'h1111;
    order = '0; both = 0;
    bus.c0_req = 1; bus.c0_we = 0; bus.c0_adrs = 20'h00001;
    bus.c1_req = 1; bus.c1_we = 0; bus.c1_adrs = 20'h00002;
    for (int i = 0; i < 10; i++) begin
      wait_ack(30, cyc, a0, a1);
      if (a0 && a1) both = 1;
      order[i] = a1;
    end
    bus.c0_req = 0; bus.c1_req = 0;
    total++;
    if (order !== exp_order || both) begin
      bad++; $display("FAIL starve_order: got %b both=%b required %b both=0", order, both, exp_order);
    end
    total++;
    if (n_long != 0 || n_both != 0) begin
      bad++; $display("FAIL cmd_pulse_shape: got long=%0d both=%0d required 0/0", n_long, n_both);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout;
    int r0, cyc; logic a0, a1;
    busy_len = 0; model_dout = 16'h5A5A;
    r0 = n_reads;
    bus.c1_req = 1; bus.c1_we = 0; bus.c1_adrs = 20'h00042;
    wait_ack(20, cyc, a0, a1);
    bus.c1_req = 0;
    // CMD, 3 WAIT_HI cycles, WAIT_LO, then DONE: ack seen 6 cycles after req
    total++;
    if (!a1 || a0 || cyc != 6) begin
      bad++; $display("FAIL timeout_ack: got a0=%b a1=%b cycles=%0d required 0/1/6", a0, a1, cyc);
    end
    total++;
    if (bus.c1_rdata !== 16'h5A5A || n_reads - r0 != 1) begin
      bad++; $display("FAIL timeout_data: got rdata=%h reads=%0d required 5A5A/1",
                      bus.c1_rdata, n_reads - r0);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int cyc, n; logic a0, a1, saw_ack;
    busy_len = 6; model_dout = 16'h0F0F;
    bus.c0_req = 1; bus.c0_we = 0; bus.c0_adrs = 20'h00555;
    n = 0;
    while (!model_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!model_busy) begin
      bad++; $display("FAIL reset_mid_busy: got busy=0 required 1 within 20 cycles");
    end
    repeat (2) @(negedge clk);  // arbiter now in WAIT_LO
    #1 resetn = 1'b0;
    #1 check_outputs_zero("reset_mid");
    saw_ack = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.c0_ack || bus.c1_ack) saw_ack = 1;
    end
    resetn = 1'b1;
    total++;
    if (saw_ack) begin
      bad++; $display("FAIL reset_mid_noack: got ack during reset required none");
    end
    wait_ack(40, cyc, a0, a1);
    bus.c0_req = 0;
    total++;
    if (!a0 || a1 || bus.c0_rdata !== 16'h0F0F) begin
      bad++; $display("FAIL reset_mid_resume: got a0=%b a1=%b rdata=%h required 1/0/0F0F",
                      a0, a1, bus.c0_rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_c0_read();
    test_c1_write();
    test_simultaneous();
    test_starve();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 time units");
    $fatal(1);
  end

endmodule
